// File: rtl/byte_uart_tx_pkg.sv
// Shared defaults and FSM encoding for the byte UART transmitter.
package byte_uart_tx_pkg;

    localparam int unsigned DATA_WIDTH_DEF     = 8;
    localparam int unsigned CLKS_PER_BIT_DEF   = 868;
    localparam int unsigned FIFO_ADDR_BITS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/byte_uart_tx_sync_fifo.sv
// Single-clock byte FIFO with registered count/full/empty and a sticky drop flag.
module byte_uart_tx_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data_c,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [ADDR_BITS:0]    count
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CNT_W = ADDR_BITS + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic                  push_ok_c;
    logic                  pop_ok_c;
    logic [CNT_W-1:0]      count_next_c;

    // A full FIFO refuses the push even if a pop frees a slot this cycle.
    assign push_ok_c = push && !full;
    assign pop_ok_c  = pop && !empty;
    assign rd_data_c = mem[rd_ptr];

    always_comb begin
        count_next_c = count;
        if (push_ok_c && !pop_ok_c) begin
            count_next_c = count + CNT_W'(1);
        end else if (!push_ok_c && pop_ok_c) begin
            count_next_c = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + ADDR_BITS'(1);
            end
            count <= count_next_c;
            full  <= (count_next_c == CNT_W'(DEPTH));
            empty <= (count_next_c == '0);
            if (push && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/byte_uart_tx.sv
// Buffers accumulator bytes and serialises each as a UART 8N1 frame, LSB first.
module byte_uart_tx #(
    parameter int unsigned DATA_WIDTH     = byte_uart_tx_pkg::DATA_WIDTH_DEF,
    parameter int unsigned CLKS_PER_BIT   = byte_uart_tx_pkg::CLKS_PER_BIT_DEF,
    parameter int unsigned FIFO_ADDR_BITS = byte_uart_tx_pkg::FIFO_ADDR_BITS_DEF
) (
    input  logic                    tx_clk,
    input  logic                    tx_rst,
    input  logic [DATA_WIDTH-1:0]   tx_byte_in,
    input  logic                    tx_byte_valid,
    output logic                    tx_serial_out,
    output logic                    tx_busy,
    output logic                    tx_fifo_full,
    output logic                    tx_overflow,
    output logic [FIFO_ADDR_BITS:0] tx_fifo_count
);

    import byte_uart_tx_pkg::*;

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W  = $clog2(DATA_WIDTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    tx_state_e             state_q;
    tx_state_e             state_d;
    logic [BAUD_W-1:0]     baud_q;
    logic [BAUD_W-1:0]     baud_d;
    logic [IDX_W-1:0]      bit_idx_q;
    logic [IDX_W-1:0]      bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                  line_d;
    logic                  busy_d;
    logic                  pop_c;
    logic                  baud_last_c;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data_c;

    byte_uart_tx_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (FIFO_ADDR_BITS)
    ) u_fifo (
        .clk       (tx_clk),
        .rst       (tx_rst),
        .push      (tx_byte_valid),
        .wr_data   (tx_byte_in),
        .pop       (pop_c),
        .rd_data_c (fifo_data_c),
        .full      (tx_fifo_full),
        .empty     (fifo_empty),
        .overflow  (tx_overflow),
        .count     (tx_fifo_count)
    );

    assign baud_last_c = (baud_q == BAUD_LAST);

    // State register.
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and FIFO pop; STOP chains straight into START when data waits.
    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_START;
                    pop_c   = 1'b1;
                end
            end
            ST_START: begin
                if (baud_last_c) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_last_c && (bit_idx_q == IDX_LAST)) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_last_c) begin
                    if (!fifo_empty) begin
                        state_d = ST_START;
                        pop_c   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values; the line is derived from the upcoming state.
    always_comb begin
        baud_d    = baud_last_c ? '0 : baud_q + BAUD_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            ST_IDLE:  baud_d = '0;
            ST_START: begin
                if (baud_last_c) begin
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (baud_last_c) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
        if (pop_c) begin
            shift_d = fifo_data_c;
            baud_d  = '0;
        end
        case (state_d)
            ST_START: line_d = 1'b0;
            ST_DATA:  line_d = shift_d[0];
            default:  line_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            baud_q        <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            tx_serial_out <= 1'b1;
            tx_busy       <= 1'b0;
        end else begin
            baud_q        <= baud_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            tx_serial_out <= line_d;
            tx_busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_byte_uart_tx.sv
// Self-checking bench for byte_uart_tx: a line monitor decodes every frame against a byte scoreboard.
module tb_byte_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       tx_rst;
    logic [7:0] tx_byte_in;
    logic       tx_byte_valid;
    logic       tx_serial_out;
    logic       tx_busy;
    logic       tx_fifo_full;
    logic       tx_overflow;
    logic [4:0] tx_fifo_count;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int frames_started = 0;
    int frames_done = 0;
    int last_start_cyc = 0;
    int prev_start_cyc = 0;
    logic [7:0] exp_q [$];

    byte_uart_tx #(
        .DATA_WIDTH     (8),
        .CLKS_PER_BIT   (CPB),
        .FIFO_ADDR_BITS (4)
    ) dut (
        .tx_clk        (clk),
        .tx_rst        (tx_rst),
        .tx_byte_in    (tx_byte_in),
        .tx_byte_valid (tx_byte_valid),
        .tx_serial_out (tx_serial_out),
        .tx_busy       (tx_busy),
        .tx_fifo_full  (tx_fifo_full),
        .tx_overflow   (tx_overflow),
        .tx_fifo_count (tx_fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: checks every cycle of each frame against the oldest expected byte.
    initial begin : uart_mon
        logic       prev;
        logic [7:0] eb;
        logic [7:0] rb;
        logic       want;
        bit         bad;
        bit         aborted;
        bit         have;
        int         bad_k;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_rst === 1'b0 && prev === 1'b1 && tx_serial_out === 1'b0) begin
                frames_started++;
                prev_start_cyc = last_start_cyc;
                last_start_cyc = cyc;
                have = 1'b0;
                eb = 8'h00;
                rb = 8'h00;
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_frame: frame started at cycle %0d, scoreboard empty", cyc);
                end else begin
                    eb = exp_q.pop_front();
                    have = 1'b1;
                end
                bad = 1'b0;
                aborted = 1'b0;
                bad_k = -1;
                for (int k = 0; k < FRAME; k++) begin
                    if (k > 0) @(negedge clk);
                    if (tx_rst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k < CPB) want = 1'b0;
                    else if (k < 9 * CPB) want = eb[3'((k - CPB) / CPB)];
                    else want = 1'b1;
                    if (k >= CPB && k < 9 * CPB && (k % CPB) == CPB / 2)
                        rb[3'((k - CPB) / CPB)] = tx_serial_out;
                    if ((tx_serial_out !== want || tx_busy !== 1'b1) && !bad) begin
                        bad = 1'b1;
                        bad_k = k;
                    end
                end
                if (!aborted && have) begin
                    tests++;
                    if (bad) begin
                        failed++;
                        $display("FAIL frame: got byte %h, want %h (first bad cycle offset %0d)", rb, eb, bad_k);
                    end
                    frames_done++;
                end
            end
            prev = tx_serial_out;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive_byte(input logic [7:0] b, input bit accept);
        @(posedge clk);
        #1;
        tx_byte_in = b;
        tx_byte_valid = 1'b1;
        if (accept) exp_q.push_back(b);
    endtask

    task automatic drive_idle();
        @(posedge clk);
        #1;
        tx_byte_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (frames_done < target) begin
            failed++;
            $display("FAIL %s_frames: done %0d, want %0d", name, frames_done, target);
        end
    endtask

    task automatic wait_cyc(input int target, input string name);
        int n = 0;
        while (cyc < target && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (cyc != target) begin
            failed++;
            $display("FAIL %s_align: cycle %0d, want %0d", name, cyc, target);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        tx_rst = 1'b1;
        tx_byte_valid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        tx_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        tx_rst = 1'b1;
        tx_byte_valid = 1'b0;
        tx_byte_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        tx_rst = 1'b0;
        @(negedge clk);
        tests += 5;
        if (tx_serial_out !== 1'b1) begin failed++; $display("FAIL reset_line: got %b, want 1", tx_serial_out); end
        if (tx_busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b, want 0", tx_busy); end
        if (tx_fifo_count !== 5'd0) begin failed++; $display("FAIL reset_count: got %0d, want 0", tx_fifo_count); end
        if (tx_fifo_full !== 1'b0) begin failed++; $display("FAIL reset_full: got %b, want 0", tx_fifo_full); end
        if (tx_overflow !== 1'b0) begin failed++; $display("FAIL reset_overflow: got %b, want 0", tx_overflow); end
    endtask

    task automatic test_single_frame();
        int base = frames_done;
        drive_byte(8'hA5, 1'b1);
        drive_idle();
        @(negedge clk);
        tests += 3;
        if (tx_fifo_count !== 5'd1) begin failed++; $display("FAIL single_count_n: got %0d, want 1", tx_fifo_count); end
        if (tx_serial_out !== 1'b1) begin failed++; $display("FAIL single_line_n: got %b, want 1", tx_serial_out); end
        if (tx_busy !== 1'b0) begin failed++; $display("FAIL single_busy_n: got %b, want 0", tx_busy); end
        @(negedge clk);
        tests += 3;
        if (tx_serial_out !== 1'b0) begin failed++; $display("FAIL single_start: got %b, want 0", tx_serial_out); end
        if (tx_busy !== 1'b1) begin failed++; $display("FAIL single_busy: got %b, want 1", tx_busy); end
        if (tx_fifo_count !== 5'd0) begin failed++; $display("FAIL single_pop: got %0d, want 0", tx_fifo_count); end
        wait_frames(base + 1, 3 * FRAME, "single");
        @(negedge clk);
        tests += 2;
        if (tx_serial_out !== 1'b1 || tx_busy !== 1'b0) begin
            failed++;
            $display("FAIL single_idle: line %b busy %b, want 1 0", tx_serial_out, tx_busy);
        end
        if (exp_q.size() != 0) begin failed++; $display("FAIL single_drain: %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int base = frames_done;
        drive_byte(8'h00, 1'b1);
        drive_byte(8'hFF, 1'b1);
        drive_idle();
        @(negedge clk);
        tests++;
        if (tx_fifo_count !== 5'd1) begin failed++; $display("FAIL b2b_count: got %0d, want 1", tx_fifo_count); end
        wait_frames(base + 2, 5 * FRAME, "b2b");
        @(negedge clk);
        tests += 3;
        if (last_start_cyc - prev_start_cyc != FRAME) begin
            failed++;
            $display("FAIL b2b_gap: got %0d cycles, want %0d", last_start_cyc - prev_start_cyc, FRAME);
        end
        if (tx_fifo_count !== 5'd0) begin failed++; $display("FAIL b2b_end_count: got %0d, want 0", tx_fifo_count); end
        if (tx_busy !== 1'b0) begin failed++; $display("FAIL b2b_end_busy: got %b, want 0", tx_busy); end
    endtask

    task automatic test_overflow();
        int base = frames_done;
        for (int i = 1; i <= 18; i++) drive_byte(8'(i), i <= 17);
        drive_idle();
        @(negedge clk);
        tests += 3;
        if (tx_fifo_count !== 5'd16) begin failed++; $display("FAIL ovf_count: got %0d, want 16", tx_fifo_count); end
        if (tx_fifo_full !== 1'b1) begin failed++; $display("FAIL ovf_full: got %b, want 1", tx_fifo_full); end
        if (tx_overflow !== 1'b1) begin failed++; $display("FAIL ovf_flag: got %b, want 1", tx_overflow); end
        wait_frames(base + 17, 18 * FRAME, "ovf");
        @(negedge clk);
        tests += 4;
        if (tx_overflow !== 1'b1) begin failed++; $display("FAIL ovf_sticky: got %b, want 1", tx_overflow); end
        if (tx_fifo_count !== 5'd0) begin failed++; $display("FAIL ovf_drained: got %0d, want 0", tx_fifo_count); end
        if (tx_fifo_full !== 1'b0) begin failed++; $display("FAIL ovf_full_clr: got %b, want 0", tx_fifo_full); end
        if (exp_q.size() != 0) begin failed++; $display("FAIL ovf_drain: %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_full_push_pop();
        int base;
        int fs;
        do_reset();
        base = frames_done;
        for (int i = 0; i < 17; i++) drive_byte(8'(8'h20 + i), 1'b1);
        drive_idle();
        @(negedge clk);
        tests += 2;
        if (tx_fifo_count !== 5'd16 || tx_fifo_full !== 1'b1) begin
            failed++;
            $display("FAIL fullpp_pre: count %0d full %b, want 16 1", tx_fifo_count, tx_fifo_full);
        end
        if (tx_overflow !== 1'b0) begin failed++; $display("FAIL fullpp_pre_ovf: got %b, want 0", tx_overflow); end
        fs = last_start_cyc;
        wait_cyc(fs + FRAME - 1, "fullpp");
        tx_byte_in = 8'h55;
        tx_byte_valid = 1'b1;
        drive_idle();
        @(negedge clk);
        tests += 3;
        if (tx_fifo_count !== 5'd15) begin failed++; $display("FAIL fullpp_count: got %0d, want 15", tx_fifo_count); end
        if (tx_overflow !== 1'b1) begin failed++; $display("FAIL fullpp_ovf: got %b, want 1", tx_overflow); end
        if (tx_fifo_full !== 1'b0) begin failed++; $display("FAIL fullpp_full: got %b, want 0", tx_fifo_full); end
        wait_frames(base + 17, 18 * FRAME, "fullpp");
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin failed++; $display("FAIL fullpp_drain: %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int fs;
        int s;
        int n = 0;
        bit bad = 1'b0;
        tests++;
        if (tx_overflow !== 1'b1) begin failed++; $display("FAIL midrst_pre_ovf: got %b, want 1", tx_overflow); end
        s = frames_started;
        drive_byte(8'h11, 1'b1);
        drive_byte(8'h22, 1'b1);
        drive_byte(8'h33, 1'b1);
        drive_byte(8'h44, 1'b1);
        drive_idle();
        while (frames_started == s && n < 20) begin
            @(negedge clk);
            n++;
        end
        fs = last_start_cyc;
        wait_cyc(fs + CPB + 3 * CPB, "midrst");
        tx_rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        tests++;
        if (tx_fifo_count !== 5'd3 || tx_busy !== 1'b1) begin
            failed++;
            $display("FAIL midrst_pre: count %0d busy %b, want 3 1", tx_fifo_count, tx_busy);
        end
        @(posedge clk);
        #1;
        tx_rst = 1'b0;
        @(negedge clk);
        tests += 4;
        if (tx_serial_out !== 1'b1) begin failed++; $display("FAIL midrst_line: got %b, want 1", tx_serial_out); end
        if (tx_busy !== 1'b0) begin failed++; $display("FAIL midrst_busy: got %b, want 0", tx_busy); end
        if (tx_fifo_count !== 5'd0) begin failed++; $display("FAIL midrst_count: got %0d, want 0", tx_fifo_count); end
        if (tx_overflow !== 1'b0) begin failed++; $display("FAIL midrst_ovf: got %b, want 0", tx_overflow); end
        s = frames_started;
        repeat (100) begin
            @(negedge clk);
            if (tx_serial_out !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad || frames_started != s) begin
            failed++;
            $display("FAIL midrst_quiet: line activity %b, new frames %0d, want 0 0", bad, frames_started - s);
        end
    endtask

    task automatic test_wrap_push_pop();
        int base = frames_done;
        int fs;
        for (int i = 0; i < 16; i++) drive_byte(8'(8'h60 + i), 1'b1);
        drive_idle();
        @(negedge clk);
        tests++;
        if (tx_fifo_count !== 5'd15) begin failed++; $display("FAIL wrap_pre: got %0d, want 15", tx_fifo_count); end
        fs = last_start_cyc;
        wait_cyc(fs + FRAME - 1, "wrap");
        tx_byte_in = 8'h70;
        tx_byte_valid = 1'b1;
        exp_q.push_back(8'h70);
        drive_idle();
        @(negedge clk);
        tests += 2;
        if (tx_fifo_count !== 5'd15) begin failed++; $display("FAIL wrap_count: got %0d, want 15", tx_fifo_count); end
        if (tx_fifo_full !== 1'b0) begin failed++; $display("FAIL wrap_full: got %b, want 0", tx_fifo_full); end
        wait_frames(base + 17, 18 * FRAME, "wrap");
        @(negedge clk);
        tests += 3;
        if (exp_q.size() != 0) begin failed++; $display("FAIL wrap_drain: %0d left, want 0", exp_q.size()); end
        if (tx_fifo_count !== 5'd0) begin failed++; $display("FAIL wrap_end_count: got %0d, want 0", tx_fifo_count); end
        if (tx_overflow !== 1'b0) begin failed++; $display("FAIL wrap_ovf: got %b, want 0", tx_overflow); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_frame();
        test_wrap_push_pop();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
